// File: rtl/fcap_pkg.sv
// Shared types and constants for the frame capture controller: FSM states,
// Avalon register addresses, CTRL/status bit positions and pixel word packing.
package fcap_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    CAPTURE = 3'd2,
    DONE    = 3'd3
  } state_t;

  localparam logic [7:0] ADDR_CTRL   = 8'd0;
  localparam logic [7:0] ADDR_ORIGIN = 8'd1;
  localparam logic [7:0] ADDR_SIZE   = 8'd2;
  localparam logic [7:0] ADDR_DATA   = 8'd3;
  localparam logic [7:0] ADDR_LEVEL  = 8'd4;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_DECIM  = 2;
  localparam int CTRL_IRQ_EN = 3;

  // One captured pixel as the HPS sees it: {R, G, B, 8'h00}
  function automatic logic [31:0] packPixel(input logic [7:0] r,
                                            input logic [7:0] g,
                                            input logic [7:0] b);
    return {r, g, b, 8'h00};
  endfunction

endpackage

// File: rtl/frame_capture_ctrl_if.sv
// Avalon-MM slave bus of the frame capture controller. The HPS side (or a
// testbench) uses the master modport, the controller uses the slave modport.
interface frame_capture_ctrl_if;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output chipselect, read, write, address, writedata,
                  input  readdata);
  modport slave  (input  chipselect, read, write, address, writedata,
                  output readdata);
endinterface

// File: rtl/fcap_fifo.sv
// Synchronous first-word-fall-through pixel FIFO. A pop on an empty FIFO is
// ignored; when full, a push is only taken if a pop happens in the same cycle.
// Flush empties the FIFO and overrides any push/pop in that cycle.
module fcap_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      level_q;
  logic             doPush;
  logic             doPop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == FULL_LEVEL);
  assign doPop   = pop_i & ~empty_o;
  assign doPush  = push_i & (~full_o | doPop);
  assign data_o  = mem_q[rdPtr_q];
  assign level_o = level_q;

  // Pointer and occupancy bookkeeping; simultaneous push+pop keeps the level
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      if (doPush && !doPop)      level_q <= level_q + 1'b1;
      else if (doPop && !doPush) level_q <= level_q - 1'b1;
    end
  end

  // Storage array, written at the tail; contents need no reset
  always_ff @(posedge clk) begin
    if (doPush && !flush_i) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/frame_capture_ctrl.sv
// Frame capture controller: arms on a CTRL start, waits for the next VSYNC
// fall, then pushes the pixels of one rectangular window of the live VGA
// stream into a FIFO that the HPS drains over Avalon-MM.
// Optional build macro FCAP_DECIMATE_EN enables the CTRL.decim 2:1 subsample.
module frame_capture_ctrl
  import fcap_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  frame_capture_ctrl_if.slave  bus,
  input  logic [7:0]           VGA_R,
  input  logic [7:0]           VGA_G,
  input  logic [7:0]           VGA_B,
  input  logic                 VGA_DE,
  input  logic                 pix_en,
  input  logic                 HSYNC,
  input  logic                 VSYNC,
  output logic                 capturing,
  output logic                 irq
);

  localparam int          LW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [9:0]  X_MAX = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_MAX = 10'(V_ACTIVE - 1);
  localparam logic [10:0] X_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] Y_LIM = 11'(V_ACTIVE);

  state_t      state_q, state_d;
  logic        hsync_q, vsync_q, hsFall, vsFall;
  logic [9:0]  xCnt_q, yCnt_q;
  logic        lineHadPix_q, pixQual;
  logic [9:0]  x0_q, y0_q, w_q, h_q;
  logic [9:0]  x0Sh_q, y0Sh_q, wSh_q, hSh_q;
  logic        irqEn_q, done_q, overflow_q, underflow_q;
  logic [31:0] readdata_q, statusWord;
  logic        wrEn, rdEn, ctrlWr, ctrlRd, startReq, abortReq, startAcc;
  logic [10:0] xEndSum, yEndSum, xEnd, yEnd;
  logic        inWin, decimOk, decimRd;
  logic        pushReq, popReq, fifoFlush, fifoFull, fifoEmpty;
  logic [31:0] fifoData;
  logic [LW-1:0] fifoLevel;
  logic        unusedWdata;

  assign wrEn     = bus.chipselect & bus.write;
  assign rdEn     = bus.chipselect & bus.read;
  assign ctrlWr   = wrEn && (bus.address == ADDR_CTRL);
  assign ctrlRd   = rdEn && (bus.address == ADDR_CTRL);
  assign abortReq = ctrlWr & bus.writedata[CTRL_ABORT];
  assign startReq = ctrlWr & bus.writedata[CTRL_START] & ~bus.writedata[CTRL_ABORT];
  assign startAcc = startReq & (state_q == IDLE);

  assign unusedWdata = ^{bus.writedata[31:26], bus.writedata[15:10],
                         bus.writedata[7:4], bus.writedata[2]};

  assign hsFall  = hsync_q & ~HSYNC;
  assign vsFall  = vsync_q & ~VSYNC;
  assign pixQual = pix_en & VGA_DE;

  assign xEndSum = {1'b0, x0Sh_q} + {1'b0, wSh_q};
  assign yEndSum = {1'b0, y0Sh_q} + {1'b0, hSh_q};
  assign xEnd    = (xEndSum > X_LIM) ? X_LIM : xEndSum;
  assign yEnd    = (yEndSum > Y_LIM) ? Y_LIM : yEndSum;
  assign inWin   = (xCnt_q >= x0Sh_q) && ({1'b0, xCnt_q} < xEnd) &&
                   (yCnt_q >= y0Sh_q) && ({1'b0, yCnt_q} < yEnd);

`ifdef FCAP_DECIMATE_EN
  logic decim_q, decimSh_q;

  // Decimation request and its copy latched at start
  always_ff @(posedge clk) begin
    if (reset) begin
      decim_q   <= 1'b0;
      decimSh_q <= 1'b0;
    end else begin
      if (ctrlWr)   decim_q   <= bus.writedata[CTRL_DECIM];
      if (startAcc) decimSh_q <= bus.writedata[CTRL_DECIM];
    end
  end

  assign decimRd = decim_q;
  assign decimOk = ~decimSh_q | ((xCnt_q[0] ~^ x0Sh_q[0]) & (yCnt_q[0] ~^ y0Sh_q[0]));
`else
  assign decimRd = 1'b0;
  assign decimOk = 1'b1;
`endif

  assign pushReq   = (state_q == CAPTURE) & pixQual & inWin & decimOk;
  assign popReq    = rdEn && (bus.address == ADDR_DATA) && !fifoEmpty;
  assign fifoFlush = startAcc | abortReq;

  fcap_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) uFifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (fifoFlush),
    .push_i  (pushReq),
    .pop_i   (popReq),
    .data_i  (packPixel(VGA_R, VGA_G, VGA_B)),
    .data_o  (fifoData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (fifoLevel)
  );

  // Sync edge detection plus raster position counters (saturating)
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      xCnt_q       <= '0;
      yCnt_q       <= '0;
      lineHadPix_q <= 1'b0;
    end else begin
      hsync_q <= HSYNC;
      vsync_q <= VSYNC;
      if (hsFall) xCnt_q <= '0;
      else if (pixQual && xCnt_q != X_MAX) xCnt_q <= xCnt_q + 10'd1;
      if (vsFall) yCnt_q <= '0;
      else if (hsFall && lineHadPix_q && yCnt_q != Y_MAX) yCnt_q <= yCnt_q + 10'd1;
      if (hsFall) lineHadPix_q <= 1'b0;
      else if (pixQual) lineHadPix_q <= 1'b1;
    end
  end

  // Capture sequencing: abort always returns to IDLE, empty windows finish at once
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (startAcc) state_d = (w_q == '0 || h_q == '0) ? DONE : ARM;
      ARM:     if (vsFall) state_d = CAPTURE;
      CAPTURE: if (({1'b0, yCnt_q} == yEnd) || vsFall) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abortReq) state_d = IDLE;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Programmable window and irq enable; the window is frozen into shadows on start
  always_ff @(posedge clk) begin
    if (reset) begin
      x0_q <= '0; y0_q <= '0; w_q <= '0; h_q <= '0;
      x0Sh_q <= '0; y0Sh_q <= '0; wSh_q <= '0; hSh_q <= '0;
      irqEn_q <= 1'b0;
    end else begin
      if (wrEn && bus.address == ADDR_ORIGIN) begin
        x0_q <= bus.writedata[9:0];
        y0_q <= bus.writedata[25:16];
      end
      if (wrEn && bus.address == ADDR_SIZE) begin
        w_q <= bus.writedata[9:0];
        h_q <= bus.writedata[25:16];
      end
      if (ctrlWr) irqEn_q <= bus.writedata[CTRL_IRQ_EN];
      if (startAcc) begin
        x0Sh_q <= x0_q; y0Sh_q <= y0_q; wSh_q <= w_q; hSh_q <= h_q;
      end
    end
  end

  // Sticky status flags: new events win over the clear-on-read of CTRL
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (startAcc) begin
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (ctrlRd) begin
        done_q      <= 1'b0;
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end
      if (state_q == DONE && !abortReq) done_q <= 1'b1;
      if (pushReq && fifoFull && !popReq && !fifoFlush) overflow_q <= 1'b1;
      if (rdEn && bus.address == ADDR_DATA && fifoEmpty) underflow_q <= 1'b1;
    end
  end

  assign statusWord = {23'b0, underflow_q, overflow_q, decimRd, irqEn_q, done_q,
                       (state_q != IDLE), state_q};

  // Registered read data, loaded one cycle after the read strobe
  always_ff @(posedge clk) begin
    if (reset) readdata_q <= '0;
    else if (rdEn) begin
      case (bus.address)
        ADDR_CTRL:   readdata_q <= statusWord;
        ADDR_ORIGIN: readdata_q <= {6'b0, y0_q, 6'b0, x0_q};
        ADDR_SIZE:   readdata_q <= {6'b0, h_q, 6'b0, w_q};
        ADDR_DATA:   readdata_q <= fifoEmpty ? 32'h0 : fifoData;
        ADDR_LEVEL:  readdata_q <= 32'(fifoLevel);
        default:     readdata_q <= '0;
      endcase
    end
  end

  assign bus.readdata = readdata_q;
  assign capturing    = (state_q == CAPTURE);
  assign irq          = done_q & irqEn_q;

endmodule
